sync_fifo_ext: RTL
==================

# sync_fifo_ext

Parametrised single-clock FIFO with selectable read mode (registered-output or first-word-fall-through), full DEPTH-entry capacity, occupancy count, programmable almost-full/almost-empty thresholds, synchronous flush and sticky overflow/underflow error flags. It is the general-purpose buffer between pipeline stages and peripherals (fetch queues, UART/bus staging) where back-pressure and level-based flow control are needed.

## Interface
- WIDTH, 32, data word width in bits (>=1)
- DEPTH, 16, number of entries; power of 2, >=2
- FWFT, 0, 0 = registered read data; 1 = first-word-fall-through
- AFULL_THRESH, DEPTH-2, almost_full_o asserts when count >= this (1..DEPTH)
- AEMPTY_THRESH, 1, almost_empty_o asserts when count <= this (0..DEPTH-1)
- clk_i  in  1  clock, all state on rising edge
- rstn_i  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous clear of contents and error flags
- push_i  in  1  write request
- push_data_i  in  WIDTH  write data
- pop_i  in  1  read request
- pop_data_o  out  WIDTH  read data (see Operation)
- full_o  out  1  count == DEPTH
- empty_o  out  1  count == 0
- almost_full_o  out  1  count >= AFULL_THRESH
- almost_empty_o  out  1  count <= AEMPTY_THRESH
- count_o  out  $clog2(DEPTH)+1  current occupancy 0..DEPTH
- overflow_o  out  1  sticky: push rejected since last reset/flush
- underflow_o  out  1  sticky: pop rejected since last reset/flush

## Operation
- Pointers head/tail are $clog2(DEPTH)+1 bits (extra wrap bit); index = low bits; full = MSBs differ, low bits equal; empty = equal. All DEPTH entries usable.
- pop_acc = pop_i && !empty_o; push_acc = push_i && (!full_o || pop_acc).
- push_acc: mem[tail] <= push_data_i, tail <= tail+1. pop_acc: head <= head+1.
- Full and push+pop: both accepted, count unchanged, entry at old head read before overwrite.
- Empty and push+pop: push accepted, pop rejected (underflow_o set); no write-through bypass.
- count: +1 on push_acc only, -1 on pop_acc only, unchanged on both/neither; arithmetic mod 2^(ptr width), never exceeds DEPTH.
- push_i && !push_acc sets overflow_o; pop_i && !pop_acc sets underflow_o; both stay set until flush or reset.
- FWFT=0: pop_data_o is a register; on pop_acc it loads mem[head] at the edge; otherwise holds last value.
- FWFT=1: pop_data_o = mem[head] combinationally; valid whenever empty_o=0; don't-care when empty.
- flush_i (priority over push/pop that cycle): head, tail, count <= 0; overflow_o, underflow_o <= 0; FWFT=0 pop_data_o <= 0; memory contents not cleared; no error flags set by that cycle's requests.
- Memory array is not reset.

## Timing
- Reset (async assert, sync-released use): count_o=0, empty_o=1, full_o=0, almost_empty_o=1 (AEMPTY_THRESH>=0), almost_full_o=0, overflow_o=0, underflow_o=0, pop_data_o=0 (FWFT=0).
- Status outputs derive combinationally from pointer/count registers: update in the cycle after the accepted operation's edge.
- FWFT=0 read latency: pop asserted cycle N -> data on pop_data_o from cycle N+1.
- FWFT=1: word pushed in cycle N visible on pop_data_o and empty_o=0 from cycle N+1; pop in cycle N consumes the word displayed in cycle N.
- Write-to-read minimum latency 1 cycle in both modes.
- Reset asserted mid-operation: all state returns to reset values immediately; in-flight request discarded.

## Test plan
- WIDTH=8, DEPTH=4, FWFT=0: push 0x11,0x22,0x33,0x44 -> full_o=1, count_o=4, almost_full_o=1; 5th push 0x55 -> overflow_o=1, contents unchanged; pop x4 -> 0x11..0x44 one cycle after each pop, then empty_o=1.
- Wrap-around: 10 interleaved push/pop of incrementing bytes over DEPTH=4 -> output sequence strictly incrementing, count_o never >4, no error flags.
- Full with push 0xAA + pop same cycle -> oldest word returned, count_o stays 4, overflow_o=0; later pops end with 0xAA.
- Empty with push 0x5A + pop same cycle -> underflow_o=1, count_o=1, next pop returns 0x5A.
- FWFT=1: push 0x3C at cycle N -> pop_data_o=0x3C, empty_o=0 at N+1 without pop; pop at N+1 -> empty_o=1 at N+2.
- Fill 3 entries, set both error flags, assert flush_i with push_i -> count_o=0, empty_o=1, flags cleared, pushed word dropped; rstn_i low mid-burst -> all reset values next sample.

Source files
------------

// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with registered or fall-through read, occupancy count,
// almost-full/empty thresholds, synchronous flush and sticky error flags.
module sync_fifo_ext #(
  parameter int WIDTH         = 32,
  parameter int DEPTH         = 16,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     almost_full_o,
  output logic                     almost_empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic                     underflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AF_T = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AE_T = PW'(AEMPTY_THRESH);

  logic [PW-1:0]    head_q, head_d, tail_q, tail_d, count_q, count_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             pop_acc, push_acc;
  logic [WIDTH-1:0] mem [DEPTH];

  // Wrap bit distinguishes full from empty so every entry is usable.
  assign empty_o  = (head_q == tail_q);
  assign full_o   = (head_q[AW] != tail_q[AW]) && (head_q[AW-1:0] == tail_q[AW-1:0]);
  assign pop_acc  = pop_i && !empty_o;
  assign push_acc = push_i && (!full_o || pop_acc);

  assign count_o        = count_q;
  assign almost_full_o  = (count_q >= AF_T);
  assign almost_empty_o = (count_q <= AE_T);
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      if (push_acc) tail_d = tail_q + PW'(1);
      if (pop_acc)  head_d = head_q + PW'(1);
      case ({push_acc, pop_acc})
        2'b10:   count_d = count_q + PW'(1);
        2'b01:   count_d = count_q - PW'(1);
        default: count_d = count_q;
      endcase
      if (push_i && !push_acc) ovf_d = 1'b1;
      if (pop_i && !pop_acc)   unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (push_acc && !flush_i) mem[tail_q[AW-1:0]] <= push_data_i;
  end

  if (FWFT != 0) begin : g_fwft
    assign pop_data_o = mem[head_q[AW-1:0]];
  end else begin : g_reg
    logic [WIDTH-1:0] rdata_q;
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i)      rdata_q <= '0;
      else if (flush_i) rdata_q <= '0;
      else if (pop_acc) rdata_q <= mem[head_q[AW-1:0]];
    end
    assign pop_data_o = rdata_q;
  end

endmodule
